// File: rtl/vga_line_fetch_if.sv
// vga_line_fetch_if: SDRAM read port between the line fetcher and the controller.
// master = line fetcher, slave = SDRAM controller side.
interface vga_line_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: fetches scaled source rows into a ping-pong line buffer and replays them.
// Optional macro VGA_BORDER_EN adds border_colour for visible pixels outside the window.
module vga_line_fetch #(
  parameter int          H_ACTIVE   = 512,
  parameter int          V_ACTIVE   = 384,
  parameter int          H_TOTAL    = 800,
  parameter int          V_TOTAL    = 525,
  parameter int          SCALE_LOG2 = 2,
  parameter int          ADDR_W     = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic             clk,
  input  logic             hard_reset_n,
  input  logic             pix_en,
  input  logic [9:0]       hpos,
  input  logic [9:0]       vpos,
  input  logic             display_on,
  vga_line_fetch_if.master mem,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             underrun
`ifdef VGA_BORDER_EN
  ,
  input  logic [11:0]      border_colour
`endif
);

  localparam int SRC_W = H_ACTIVE >> SCALE_LOG2;
  localparam int CW    = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int BW    = $clog2(2 * SRC_W);
  localparam logic [9:0] SMASK = 10'((1 << SCALE_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_col;
  logic [ADDR_W-1:0] r_addr;
  logic              r_disp_bank;
  logic              r_pending;
  logic              r_underrun;
  logic              r_fetch_line;
  logic [11:0]       r_rgb;
  logic [11:0]       r_buf [2*SRC_W];

  logic [9:0]        w_next_y;
  logic [9:0]        w_src_row;
  logic [ADDR_W-1:0] w_row_base;
  logic              w_trig;
  logic              w_eol;
  logic              w_abort;
  logic              w_swap;
  logic              w_last;
  logic              w_wr_en;
  logic              w_in_win;
  logic [BW-1:0]     w_wr_idx;
  logic [BW-1:0]     w_rd_idx;
  logic [11:0]       w_pix;
  logic              w_unused;

  assign w_next_y   = (vpos == 10'(V_TOTAL - 1)) ? 10'd0
                                                 : vpos + 10'd1;
  assign w_src_row  = w_next_y >> SCALE_LOG2;
  assign w_row_base = ADDR_W'(32'(BASE_ADDR)
                    + 32'(w_src_row) * 32'(SRC_W));

  assign w_trig  = pix_en
                && (hpos == 10'(H_ACTIVE))
                && (w_next_y < 10'(V_ACTIVE))
                && ((w_next_y & SMASK) == 10'd0);
  assign w_eol   = pix_en
                && (hpos == 10'(H_TOTAL - 1))
                && r_fetch_line;
  assign w_abort = (w_trig || w_eol) && (r_state == S_REQ);
  assign w_swap  = w_eol
                && (r_pending || (r_state == S_DONE));
  assign w_last  = (r_col == CW'(SRC_W - 1));
  assign w_wr_en = (r_state == S_REQ) && mem.mem_ack && !w_abort;

  assign w_wr_idx = r_disp_bank ? BW'(r_col)
                                : BW'(SRC_W) + BW'(r_col);
  assign w_rd_idx = r_disp_bank ? BW'(SRC_W) + BW'(hpos >> SCALE_LOG2)
                                : BW'(hpos >> SCALE_LOG2);
  assign w_in_win = (hpos < 10'(H_ACTIVE)) && (vpos < 10'(V_ACTIVE));

`ifdef VGA_BORDER_EN
  assign w_unused = ^mem.mem_rdata[15:12];
`else
  assign w_unused = ^{display_on, mem.mem_rdata[15:12]};
`endif

  // fetch FSM state register
  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // fetch FSM next state: a new trigger always restarts the row
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_trig) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_trig)
          w_state_nxt = S_REQ;
        else if (w_eol)
          w_state_nxt = S_IDLE;
        else if (mem.mem_ack && w_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = w_trig ? S_REQ : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // fetch FSM outputs: request held for the whole row
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_addr = r_addr;
    if (r_state == S_REQ) mem.mem_req = 1'b1;
  end

  // column/address counters, bank swap, sticky underrun, pixel register
  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      r_col        <= '0;
      r_addr       <= '0;
      r_disp_bank  <= 1'b0;
      r_pending    <= 1'b0;
      r_underrun   <= 1'b0;
      r_fetch_line <= 1'b0;
      r_rgb        <= 12'h000;
    end else begin
      if (w_trig) begin
        r_col  <= '0;
        r_addr <= w_row_base;
      end else if (w_wr_en) begin
        r_col  <= w_last ? '0 : r_col + CW'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_trig || w_eol)
        r_pending <= 1'b0;
      else if (r_state == S_DONE)
        r_pending <= 1'b1;

      if (w_swap) r_disp_bank <= ~r_disp_bank;
      if (w_abort) r_underrun <= 1'b1;

      if (w_trig)
        r_fetch_line <= 1'b1;
      else if (pix_en && (hpos == 10'(H_TOTAL - 1)))
        r_fetch_line <= 1'b0;

      if (pix_en) r_rgb <= w_pix;
    end
  end

  // line buffer write port; contents need no reset
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_idx] <= mem.mem_rdata[11:0];
  end

  // pixel select: buffer inside the window, border or black outside
  always_comb begin
    w_pix = 12'h000;
    if (w_in_win)
      w_pix = r_buf[w_rd_idx];
`ifdef VGA_BORDER_EN
    else if (display_on)
      w_pix = border_colour;
`endif
  end

  assign red      = r_rgb[3:0];
  assign green    = r_rgb[7:4];
  assign blue     = r_rgb[11:8];
  assign underrun = r_underrun;

endmodule
